vga_stream_timing: RTL

- Parametrised successor of the fixed 800x600 monochrome VGA timing block.
- Generates h_sync and v_sync with configurable porches and polarity.
- Serialises BPP-bit pixels from WORD_W-bit words, fetched through a valid/ready handshake with a one-entry prefetch buffer.
- Sits between the framebuffer reader and the DAC/pins, and reports underrun and line/frame boundaries.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_stream_timing_if.sv | 13 +
 rtl/pixel_serializer.sv | 117 +++++++++++
 rtl/vga_stream_timing.sv | 116 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and sizing helpers.
// Holds the 800x600@60 and 640x480@60 timings plus total/width functions.
package vga_pkg;

    // 800x600@60 (40 MHz pixel clock)
    localparam int unsigned SVGA_H_ACTIVE = 800;
    localparam int unsigned SVGA_H_FP     = 40;
    localparam int unsigned SVGA_H_SW     = 128;
    localparam int unsigned SVGA_H_BP     = 88;
    localparam int unsigned SVGA_V_ACTIVE = 600;
    localparam int unsigned SVGA_V_FP     = 1;
    localparam int unsigned SVGA_V_SW     = 4;
    localparam int unsigned SVGA_V_BP     = 23;

    // 640x480@60 (25.175 MHz pixel clock)
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SW     = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SW     = 2;
    localparam int unsigned VGA_V_BP     = 33;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sw, input int unsigned bp);
        return active + fp + sw + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sw, input int unsigned bp);
        return active + fp + sw + bp;
    endfunction

    // Width of a counter spanning 0..total-1, never narrower than one bit.
    function automatic int unsigned count_w(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_stream_timing_if.sv
// Pixel-word stream between the framebuffer reader (master) and the timing block (slave).
interface vga_stream_timing_if #(
    parameter int unsigned WORD_W = 16
) ();

    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/pixel_serializer.sv
// Prefetch register plus shift register turning pixel words into a pixel stream.
// Define VGA_PIXEL_DOUBLE_EN to hold each source pixel for two active cycles.
module pixel_serializer
    import vga_pkg::*;
#(
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned BPP      = 1,
    parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
    parameter int unsigned HCW      = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    vga_stream_timing_if.slave word_if,
    input  logic               active_i,
    input  logic               frame_start_i,
    input  logic [HCW-1:0]     hc_i,
    output logic [BPP-1:0]     pixel_o,
    output logic               underrun_o
);

    localparam int unsigned PPW = WORD_W / BPP;
`ifdef VGA_PIXEL_DOUBLE_EN
    localparam int unsigned LOAD_PERIOD = 2 * PPW;
`else
    localparam int unsigned LOAD_PERIOD = PPW;
`endif

    if (WORD_W % BPP != 0) begin : g_bad_bpp
        $error("WORD_W must be a multiple of BPP");
    end
    if (H_ACTIVE % LOAD_PERIOD != 0) begin : g_bad_h_active
        $error("H_ACTIVE must be a multiple of the pixels consumed per word");
    end

    logic [WORD_W-1:0] next_word_q, next_word_d;
    logic              next_full_q, next_full_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BPP-1:0]    pixel_q, pixel_d;
    logic              underrun_q, underrun_d;
`ifdef VGA_PIXEL_DOUBLE_EN
    logic              hold_q, hold_d;
`endif
    logic [WORD_W-1:0] fetched;
    logic              xfer;
    logic              load;

    assign word_if.word_ready = !next_full_q && !rst_i;

    always_comb begin
        xfer        = word_if.word_valid && !next_full_q && !rst_i;
        load        = active_i && ((32'(hc_i) % LOAD_PERIOD) == 0);
        fetched     = next_full_q ? next_word_q : '0;
        next_word_d = next_word_q;
        next_full_d = next_full_q;
        shreg_d     = shreg_q;
        pixel_d     = '0;
        underrun_d  = underrun_q && !frame_start_i;
`ifdef VGA_PIXEL_DOUBLE_EN
        hold_d      = hold_q;
`endif
        if (load) begin
            pixel_d     = fetched[WORD_W-1 -: BPP];
            next_full_d = 1'b0;
            if (!next_full_q) begin
                underrun_d = 1'b1;
            end
`ifdef VGA_PIXEL_DOUBLE_EN
            shreg_d = fetched;
            hold_d  = 1'b1;
`else
            shreg_d = fetched << BPP;
`endif
        end else if (active_i) begin
            pixel_d = shreg_q[WORD_W-1 -: BPP];
`ifdef VGA_PIXEL_DOUBLE_EN
            // Shift only after the second cycle of each held pixel.
            if (hold_q) begin
                shreg_d = shreg_q << BPP;
            end
            hold_d = !hold_q;
`else
            shreg_d = shreg_q << BPP;
`endif
        end
        // A transfer can only coincide with an underrun load, and it must win.
        if (xfer) begin
            next_word_d = word_if.word_data;
            next_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_word_q <= '0;
            next_full_q <= 1'b0;
            shreg_q     <= '0;
            pixel_q     <= '0;
            underrun_q  <= 1'b0;
`ifdef VGA_PIXEL_DOUBLE_EN
            hold_q      <= 1'b0;
`endif
        end else begin
            next_word_q <= next_word_d;
            next_full_q <= next_full_d;
            shreg_q     <= shreg_d;
            pixel_q     <= pixel_d;
            underrun_q  <= underrun_d;
`ifdef VGA_PIXEL_DOUBLE_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign pixel_o    = pixel_q;
    assign underrun_o = underrun_q;

endmodule

// File: rtl/vga_stream_timing.sv
// Parametrised VGA timing generator fed by a valid/ready pixel-word stream.
// Define VGA_PIXEL_DOUBLE_EN to show every source pixel for two active cycles.
module vga_stream_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = SVGA_H_ACTIVE,
    parameter int unsigned H_FP      = SVGA_H_FP,
    parameter int unsigned H_SW      = SVGA_H_SW,
    parameter int unsigned H_BP      = SVGA_H_BP,
    parameter int unsigned V_ACTIVE  = SVGA_V_ACTIVE,
    parameter int unsigned V_FP      = SVGA_V_FP,
    parameter int unsigned V_SW      = SVGA_V_SW,
    parameter int unsigned V_BP      = SVGA_V_BP,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned BPP       = 1,
    localparam int unsigned H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SW, H_BP),
    localparam int unsigned V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SW, V_BP),
    localparam int unsigned HCW      = count_w(H_TOTAL),
    localparam int unsigned VCW      = count_w(V_TOTAL)
) (
    input  logic               CLK_VGA,
    input  logic               reset,
    vga_stream_timing_if.slave word_if,
    output logic [BPP-1:0]     pixel,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [HCW-1:0]     h_count,
    output logic [VCW-1:0]     v_count,
    output logic               end_of_line,
    output logic               end_of_frame,
    output logic               underrun
);

    logic [HCW-1:0] hc_q, hc_d, h_count_q;
    logic [VCW-1:0] vc_q, vc_d, v_count_q;
    logic           h_sync_q, h_sync_d;
    logic           v_sync_q, v_sync_d;
    logic           de_q, de_d;
    logic           eol_q, eol_d;
    logic           eof_q, eof_d;
    logic           line_last, frame_last, active, frame_start;

    always_comb begin
        line_last   = (32'(hc_q) == H_TOTAL - 1);
        frame_last  = (32'(vc_q) == V_TOTAL - 1);
        active      = (32'(hc_q) < H_ACTIVE) && (32'(vc_q) < V_ACTIVE);
        frame_start = (hc_q == '0) && (vc_q == '0);

        hc_d = line_last ? '0 : hc_q + HCW'(1);
        vc_d = vc_q;
        if (line_last) begin
            vc_d = frame_last ? '0 : vc_q + VCW'(1);
        end

        h_sync_d = ((32'(hc_q) >= H_ACTIVE + H_FP) && (32'(hc_q) < H_ACTIVE + H_FP + H_SW))
                   ? HSYNC_POL : ~HSYNC_POL;
        v_sync_d = ((32'(vc_q) >= V_ACTIVE + V_FP) && (32'(vc_q) < V_ACTIVE + V_FP + V_SW))
                   ? VSYNC_POL : ~VSYNC_POL;
        de_d     = active;
        eol_d    = line_last;
        eof_d    = line_last && frame_last;
    end

    // Outputs describe the counter state of the previous cycle.
    always_ff @(posedge CLK_VGA) begin
        if (reset) begin
            hc_q      <= '0;
            vc_q      <= '0;
            h_count_q <= '0;
            v_count_q <= '0;
            h_sync_q  <= ~HSYNC_POL;
            v_sync_q  <= ~VSYNC_POL;
            de_q      <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            h_count_q <= hc_q;
            v_count_q <= vc_q;
            h_sync_q  <= h_sync_d;
            v_sync_q  <= v_sync_d;
            de_q      <= de_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
        end
    end

    pixel_serializer #(
        .WORD_W   (WORD_W),
        .BPP      (BPP),
        .H_ACTIVE (H_ACTIVE),
        .HCW      (HCW)
    ) u_serializer (
        .clk_i         (CLK_VGA),
        .rst_i         (reset),
        .word_if       (word_if),
        .active_i      (active),
        .frame_start_i (frame_start),
        .hc_i          (hc_q),
        .pixel_o       (pixel),
        .underrun_o    (underrun)
    );

    assign h_sync       = h_sync_q;
    assign v_sync       = v_sync_q;
    assign de           = de_q;
    assign h_count      = h_count_q;
    assign v_count      = v_count_q;
    assign end_of_line  = eol_q;
    assign end_of_frame = eof_q;

endmodule
